// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
// Optional clamp logic in the top is enabled by SERIAL_ADD_SUB_SATURATE_EN.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed extreme of a w-bit two's-complement number, zero-extended to 64 bits.
  function automatic logic [63:0] signed_extreme(input int w, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (w - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/serial_add_sub_chunk_adder.sv
// Combinational N-bit ripple adder built from per-bit full adders.
module chunk_adder #(
  parameter int N = 2
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign cout = c[N];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement add/subtract, CHUNK bits per clock, LSB first.
// Define SERIAL_ADD_SUB_SATURATE_EN to clamp overflowing results to the signed extremes.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int W     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         carry_out,
  output logic         overflow,
  output logic [1:0]   state_dbg
);

  localparam int NCHUNK = W / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (W < 2 || CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_params
    $error("serial_add_sub: W must be >= 2 and an integer multiple of CHUNK");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and operands/results are
  // captured/released exactly on those edges.

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   opa, opb, res;
  logic [W-1:0]   opa_nx, opb_nx, res_nx;
  logic           carry;
  logic           sign_a, sign_b;
  logic [CHUNK-1:0] csum;
  logic           cout;
  logic           last;
  logic           ovf_nx;
  logic [W-1:0]   s_fin;

  chunk_adder #(.N(CHUNK)) u_chunk (
    .x    (opa[CHUNK-1:0]),
    .y    (opb[CHUNK-1:0]),
    .cin  (carry),
    .sum  (csum),
    .cout (cout)
  );

  // Operands shift right so the active chunk is always at the bottom;
  // the result fills from the MSB side so the first chunk ends up lowest.
  if (CHUNK < W) begin : g_shift
    assign opa_nx = {{CHUNK{1'b0}}, opa[W-1:CHUNK]};
    assign opb_nx = {{CHUNK{1'b0}}, opb[W-1:CHUNK]};
    assign res_nx = {csum, res[W-1:CHUNK]};
  end else begin : g_single
    assign opa_nx = opa;
    assign opb_nx = opb;
    assign res_nx = csum;
  end

  assign last   = (cnt == CW'(NCHUNK - 1));
  assign ovf_nx = (sign_a == sign_b) && (res_nx[W-1] != sign_a);

`ifdef SERIAL_ADD_SUB_SATURATE_EN
  localparam logic [63:0] SMAX64 = signed_extreme(W, 1'b0);
  localparam logic [63:0] SMIN64 = signed_extreme(W, 1'b1);
  localparam logic [W-1:0] SMAX  = SMAX64[W-1:0];
  localparam logic [W-1:0] SMIN  = SMIN64[W-1:0];
  assign s_fin = ovf_nx ? (sign_a ? SMIN : SMAX) : res_nx;
`else
  assign s_fin = res_nx;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      carry     <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      s         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B here, the +1 rides in as carry-in.
            opa    <= a;
            opb    <= (sub == OP_SUB) ? ~b : b;
            carry  <= sub;
            sign_a <= a[W-1];
            sign_b <= (sub == OP_SUB) ? ~b[W-1] : b[W-1];
            cnt    <= '0;
          end
        end
        RUN: begin
          opa   <= opa_nx;
          opb   <= opb_nx;
          res   <= res_nx;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            s         <= s_fin;
            carry_out <= cout;
            overflow  <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: W=8/CHUNK=2 main instance plus a W=16/CHUNK=16 instance.
module tb_serial_add_sub;
  import serial_add_sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
  logic [7:0] a, b, s;
  logic [1:0] state_dbg;

  logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16, carry_out16, overflow16;
  logic [15:0] a16, b16, s16;
  logic [1:0]  state_dbg16;

  serial_add_sub #(.W(8), .CHUNK(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .carry_out(carry_out), .overflow(overflow), .state_dbg(state_dbg)
  );

  serial_add_sub #(.W(16), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
    .s(s16), .carry_out(carry_out16), .overflow(overflow16), .state_dbg(state_dbg16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;
  logic [9:0]  exp_q[$];    // {overflow, carry_out, s}
  logic [17:0] exp16_q[$];  // {overflow, carry_out, s}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model from signed/unsigned integer arithmetic.
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic op);
    int r;
    logic [7:0] rs;
    logic c, v;
    r  = op ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    v  = (r > 127) || (r < -128);
    c  = op ? (x >= y) : ((int'(x) + int'(y)) > 255);
    rs = r[7:0];
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    if (v) rs = (r > 0) ? 8'h7F : 8'h80;
`endif
    return {v, c, rs};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic op,
                       input int hold, input bit poke);
    int waitc;
    int lat;
    logic [9:0] e;
    waitc = 0;
    while (!in_ready && waitc < 50) begin tick(); waitc++; end
    check("in_ready_wait", 32'(waitc < 50), 32'd1);
    a = x; b = y; sub = op; in_valid = 1'b1;
    exp_q.push_back(model8(x, y, op));
    tick();
    in_valid = 1'b0;
    check("in_ready_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check("latency", lat, 32'd4);
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        a = ~x; b = ~y; sub = ~op; in_valid = 1'b1;
      end
      check("hold_s",     32'(s),         32'(e[7:0]));
      check("hold_cout",  32'(carry_out), 32'(e[8]));
      check("hold_ovf",   32'(overflow),  32'(e[9]));
      check("hold_ready", 32'(in_ready),  32'd0);
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    check("s",         32'(s),         32'(e[7:0]));
    check("carry_out", 32'(carry_out), 32'(e[8]));
    check("overflow",  32'(overflow),  32'(e[9]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready),  32'd1);
    // Results hold in IDLE until the next completion.
    check("idle_hold_s", 32'(s), 32'(e[7:0]));
  endtask

  task automatic do_op16(input logic [15:0] x, input logic [15:0] y, input logic op,
                         input logic [17:0] e_in);
    int lat;
    logic [17:0] e;
    a16 = x; b16 = y; sub16 = op; in_valid16 = 1'b1;
    exp16_q.push_back(e_in);
    check("in_ready16", 32'(in_ready16), 32'd1);
    tick();
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 50) begin tick(); lat++; end
    check("latency16", lat, 32'd1);
    e = exp16_q.pop_front();
    check("s16",     32'(s16),         32'(e[15:0]));
    check("cout16",  32'(carry_out16), 32'(e[16]));
    check("ovf16",   32'(overflow16),  32'(e[17]));
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
    check("drain16", 32'(out_valid16), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rx, ry;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s",         32'(s),         32'd0);
    check("rst_cout",      32'(carry_out), 32'd0);
    check("rst_ovf",       32'(overflow),  32'd0);
    check("rst_state",     32'(state_dbg), 32'(IDLE));

    // Directed cases
    do_op(8'd100, 8'd27, OP_ADD, 0, 1'b0);
    do_op(8'd100, 8'd28, OP_ADD, 0, 1'b0);
    do_op(8'h80,  8'd1,  OP_SUB, 0, 1'b0);
    do_op(8'd5,   8'd7,  OP_SUB, 0, 1'b0);
    do_op(8'd7,   8'd5,  OP_SUB, 0, 1'b0);
    do_op(8'd0,   8'h80, OP_SUB, 0, 1'b0);
    do_op(8'hFF,  8'hFF, OP_ADD, 0, 1'b0);

    // Back-pressure with a second request poked while results wait
    do_op(8'd33, 8'd44, OP_ADD, 5, 1'b1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (out_valid) seen++;
      end
      check("no_phantom_op", seen, 32'd0);
    end

    // Reset during the 2nd RUN cycle
    a = 8'd50; b = 8'd50; sub = OP_ADD; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_s",     32'(s),         32'd0);
    check("mid_rst_cout",  32'(carry_out), 32'd0);
    check("mid_rst_ovf",   32'(overflow),  32'd0);
    do_op(8'd3, 8'd4, OP_ADD, 0, 1'b0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      if (i % 6 == 0) ry = 8'h80;
      do_op(rx, ry, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
    end

    // Single-cycle configuration, W=16, CHUNK=16
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    do_op16(16'h7FFF, 16'h0001, OP_ADD, {1'b1, 1'b0, 16'h7FFF});
    do_op16(16'h8000, 16'h0001, OP_SUB, {1'b1, 1'b1, 16'h8000});
`else
    do_op16(16'h7FFF, 16'h0001, OP_ADD, {1'b1, 1'b0, 16'h8000});
    do_op16(16'h8000, 16'h0001, OP_SUB, {1'b1, 1'b1, 16'h7FFF});
`endif
    do_op16(16'h1234, 16'h0FFF, OP_SUB, {1'b0, 1'b1, 16'h0235});

    check("queue_empty", exp_q.size() + exp16_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
